// File: rtl/mat_fifo_prefetch_gen_if.sv
// Handshake bundle for the prefetch FIFO: write side, first-word-fall-through
// read side, occupancy and status flags.
interface mat_fifo_prefetch_gen_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 10
);
    logic                   flush;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   wr_vld;
    logic                   rd_en;
    logic                   rd_vld;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DEPTH_WIDTH:0]   data_cnt;
    logic                   almost_full;
    logic                   almost_empty;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  wr_vld, rd_vld, rd_data, data_cnt,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output wr_vld, rd_vld, rd_data, data_cnt,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/mat_fifo_prefetch_gen.sv
// Single-clock first-word-fall-through FIFO: registered-read RAM feeding one
// output prefetch register, with occupancy, level flags and sticky error flags.
module mat_fifo_prefetch_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 10,
    parameter int AF_LEVEL    = 1020,
    parameter int AE_LEVEL    = 4
) (
    input logic                    clk,
    input logic                    rst,
    mat_fifo_prefetch_gen_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int CNT_W = DEPTH_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  ram_q;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]       data_cnt;
    logic [CNT_W-1:0]       ram_cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [CNT_W-1:0]       ram_cnt_nxt;
    logic                   out_vld;
    logic                   in_flight;
    logic                   wr_vld;
    logic                   almost_full;
    logic                   almost_empty;
    logic                   overflow;
    logic                   underflow;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   load_out;
    logic                   issue;

    // ram_cnt tracks words still unread in the RAM; data_cnt also includes the
    // in-flight read and the output register.
    always_comb begin
        wr_acc      = bus.wr_en & wr_vld & ~bus.flush;
        rd_acc      = bus.rd_en & out_vld & ~bus.flush;
        load_out    = in_flight & (~out_vld | rd_acc);
        issue       = ~bus.flush & (ram_cnt != '0) & (~out_vld | rd_acc)
                      & (~in_flight | load_out);
        cnt_nxt     = data_cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        ram_cnt_nxt = ram_cnt + CNT_W'(wr_acc) - CNT_W'(issue);
    end

    // NOTE: the storage array and its read register carry no reset; clearing
    // pointers and valid bits is enough, and it keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.wr_data;
        end
        if (issue) begin
            ram_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_cnt     <= '0;
            ram_cnt      <= '0;
            out_vld      <= 1'b0;
            out_data     <= '0;
            in_flight    <= 1'b0;
            wr_vld       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_cnt     <= '0;
            ram_cnt      <= '0;
            out_vld      <= 1'b0;
            in_flight    <= 1'b0;
            wr_vld       <= 1'b1;
            almost_full  <= ('0 >= AF_CNT);
            almost_empty <= ('0 <= AE_CNT);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            data_cnt <= cnt_nxt;
            ram_cnt  <= ram_cnt_nxt;

            // Level flags come from the next count so they track data_cnt exactly.
            wr_vld       <= (cnt_nxt < DEPTH_CNT);
            almost_full  <= (cnt_nxt >= AF_CNT);
            almost_empty <= (cnt_nxt <= AE_CNT);

            if (load_out) begin
                out_vld  <= 1'b1;
                out_data <= ram_q;
            end else if (rd_acc) begin
                out_vld <= 1'b0;
            end
            in_flight <= issue | (in_flight & ~load_out);

            if (bus.wr_en & ~wr_vld) begin
                overflow <= 1'b1;
            end
            if (bus.rd_en & ~out_vld) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.wr_vld       = wr_vld;
    assign bus.rd_vld       = out_vld;
    assign bus.rd_data      = out_data;
    assign bus.data_cnt     = data_cnt;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_mat_fifo_prefetch_gen.sv
// Self-checking bench for mat_fifo_prefetch_gen: directed scenarios plus random
// traffic, all checked against a queue-based model of the FIFO contents.
module tb_mat_fifo_prefetch_gen;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = 14;
    localparam int AE    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mat_fifo_prefetch_gen_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bus ();

    mat_fifo_prefetch_gen #(
        .DATA_WIDTH (DW),
        .DEPTH_WIDTH(AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_q[$];
    bit          ovf_m = 1'b0;
    bit          udf_m = 1'b0;
    int          quiet = 0;
    bit          last_pop = 1'b0;
    int          pops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with what the model's contents imply.
    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".data_cnt"}, 64'(bus.data_cnt), 64'(n));
        check({tag, ".wr_vld"}, 64'(bus.wr_vld), 64'(n < DEPTH));
        check({tag, ".almost_full"}, 64'(bus.almost_full), 64'(n >= AF));
        check({tag, ".almost_empty"}, 64'(bus.almost_empty), 64'(n <= AE));
        check({tag, ".overflow"}, 64'(bus.overflow), 64'(ovf_m));
        check({tag, ".underflow"}, 64'(bus.underflow), 64'(udf_m));
        if (n == 0) begin
            check({tag, ".rd_vld_empty"}, 64'(bus.rd_vld), 64'd0);
        end
        // A stored word must reach the head within the write-to-visibility latency.
        if (quiet >= 3) begin
            check({tag, ".rd_vld_live"}, 64'(bus.rd_vld), 64'd1);
        end
    endtask

    // One clock: drive inputs just after an edge, sample before the next edge,
    // update the model at the edge, then check outputs 1 time unit later.
    task automatic step(input bit we, input logic [7:0] wd, input bit re, input bit fl);
        logic       pre_rd_vld;
        logic [7:0] pre_rd_data;
        bit         full;
        bit         wacc;
        bit         racc;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.flush   = fl;
        #3;
        pre_rd_vld  = bus.rd_vld;
        pre_rd_data = bus.rd_data;
        @(posedge clk);
        #1;
        racc = 1'b0;
        if (fl) begin
            model_q.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
            quiet = 0;
        end else begin
            full = (model_q.size() >= DEPTH);
            wacc = we && !full;
            racc = re && (pre_rd_vld === 1'b1);
            if (we && full) ovf_m = 1'b1;
            if (re && (pre_rd_vld !== 1'b1)) udf_m = 1'b1;
            if (racc) begin
                if (model_q.size() == 0) begin
                    check("pop_on_empty", 64'(pre_rd_vld), 64'd0);
                end else begin
                    check("pop_data", 64'(pre_rd_data), 64'(model_q[0]));
                    void'(model_q.pop_front());
                end
            end
            if (wacc) model_q.push_back(wd);
            if (model_q.size() > 0 && !racc) quiet++;
            else quiet = 0;
        end
        last_pop = racc;
        if (racc) pops++;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        check_state("step");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".wr_vld"}, 64'(bus.wr_vld), 64'd1);
        check({tag, ".rd_vld"}, 64'(bus.rd_vld), 64'd0);
        check({tag, ".rd_data"}, 64'(bus.rd_data), 64'd0);
        check({tag, ".data_cnt"}, 64'(bus.data_cnt), 64'd0);
        check({tag, ".almost_full"}, 64'(bus.almost_full), 64'd0);
        check({tag, ".almost_empty"}, 64'(bus.almost_empty), 64'd1);
        check({tag, ".overflow"}, 64'(bus.overflow), 64'd0);
        check({tag, ".underflow"}, 64'(bus.underflow), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;

        // Reset state, then release just after an edge.
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First word: written at edge 1, visible after edge 3.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("first.cnt_after_edge1", 64'(bus.data_cnt), 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("first.rd_vld", 64'(bus.rd_vld), 64'd1);
        check("first.rd_data", 64'(bus.rd_data), 64'hA5);
        check("first.almost_empty", 64'(bus.almost_empty), 64'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to capacity, overflow, and pop-while-full with a rejected write.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            if (i == AF - 2) check("fill.af_before", 64'(bus.almost_full), 64'd0);
            if (i == AF - 1) check("fill.af_rise", 64'(bus.almost_full), 64'd1);
        end
        check("fill.wr_vld_full", 64'(bus.wr_vld), 64'd0);
        check("fill.cnt_full", 64'(bus.data_cnt), 64'(DEPTH));
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("fill.overflow", 64'(bus.overflow), 64'd1);
        check("fill.cnt_held", 64'(bus.data_cnt), 64'(DEPTH));
        step(1'b1, 8'hEF, 1'b1, 1'b0);
        check("fill.pop_while_full", 64'(bus.data_cnt), 64'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("fill.drained", 64'(bus.data_cnt), 64'd0);

        // Underflow is sticky through writes and reads, cleared by flush.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf.set", 64'(bus.underflow), 64'd1);
        check("udf.cnt_zero", 64'(bus.data_cnt), 64'd0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf.sticky", 64'(bus.underflow), 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("udf.flush_clears", 64'(bus.underflow), 64'd0);

        // Streaming 0..99 with continuous pops: first pop at edge 4, then one per edge.
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            if (i >= 10) check("stream.cnt_steady", 64'(bus.data_cnt), 64'd3);
        end
        check("stream.pop_count", 64'(pops), 64'd97);
        for (int i = 0; i < 20 && model_q.size() != 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream.drained", 64'(bus.data_cnt), 64'd0);
        check("stream.total_pops", 64'(pops), 64'd100);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Flush mid-stream together with wr_en and rd_en.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        check("flush.cnt", 64'(bus.data_cnt), 64'd0);
        check("flush.rd_vld", 64'(bus.rd_vld), 64'd0);
        check("flush.underflow", 64'(bus.underflow), 64'd0);
        check("flush.overflow", 64'(bus.overflow), 64'd0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("flush.head_vld", 64'(bus.rd_vld), 64'd1);
        check("flush.head_data", 64'(bus.rd_data), 64'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 2));
        end

        // Asynchronous reset between edges with 8 words stored.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("arst.pre_cnt", 64'(bus.data_cnt), 64'd8);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("arst");
        model_q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        quiet = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("arst.no_stale", 64'(bus.rd_vld), 64'd0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("arst.first_write", 64'(bus.data_cnt), 64'd1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("arst.head", 64'(bus.rd_data), 64'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
